// File: rtl/neighbor_table_pq.sv
// Neighbour table with known-cluster-head list and running max-Q tracker.
// Updates are searched, written, CH-deduplicated and rescanned one entry per cycle.
module neighbor_table_pq #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CH_DEPTH   = 8,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  clear,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WORD_WIDTH-1:0] wr_id,
  input  logic [WORD_WIDTH-1:0] wr_cluster,
  input  logic [WORD_WIDTH-1:0] wr_energy,
  input  logic [WORD_WIDTH-1:0] wr_hops,
  input  logic [WORD_WIDTH-1:0] wr_q,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [WORD_WIDTH-1:0] rd_id,
  output logic [WORD_WIDTH-1:0] rd_cluster,
  output logic [WORD_WIDTH-1:0] rd_energy,
  output logic [WORD_WIDTH-1:0] rd_hops,
  output logic [WORD_WIDTH-1:0] rd_q,
  output logic                  rd_hit,
  input  logic [IDX_W-1:0]      ch_rd_idx,
  output logic [WORD_WIDTH-1:0] ch_rd_id,
  output logic [IDX_W:0]        neighbor_count,
  output logic [IDX_W:0]        ch_count,
  output logic [WORD_WIDTH-1:0] max_q,
  output logic [WORD_WIDTH-1:0] max_q_id,
  output logic [IDX_W-1:0]      max_q_idx,
  output logic                  done,
  output logic                  overflow,
  output logic                  ch_overflow
);

  localparam int unsigned W   = WORD_WIDTH;
  localparam int unsigned CW  = IDX_W + 1;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CAW = $clog2(CH_DEPTH);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] CH_DEPTH_C = CW'(CH_DEPTH);

  typedef enum logic [2:0] {IDLE, SRCH, WRITE, CHSRCH, QSCAN} state_e;

  state_e state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d, cnt_q, cnt_d, ch_cnt_q, ch_cnt_d;
  logic             hit_q, hit_d;
  logic [W-1:0]     best_q, best_d, max_q_q, max_q_d, max_q_id_q, max_q_id_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d, max_q_idx_q, max_q_idx_d;
  logic             done_q, done_d, ovf_q, ovf_d, ch_ovf_q, ch_ovf_d;
  logic [W-1:0]     rec_id_q, rec_cl_q, rec_en_q, rec_hp_q, rec_qv_q;
  logic [DEPTH-1:0][W-1:0]    id_mem, cl_mem, en_mem, hp_mem, q_mem;
  logic [CH_DEPTH-1:0][W-1:0] ch_mem;
  logic [W-1:0]     rd_id_q, rd_cl_q, rd_en_q, rd_hp_q, rd_qv_q, ch_rd_q;
  logic             rd_hit_q;
  logic             acc_c, tbl_we_c, ch_we_c;
  logic [AW-1:0]    tbl_wa_c;
  logic [CAW-1:0]   ch_wa_c;
  logic [W-1:0]     id_at_c, q_at_c, ch_at_c;
  logic             rd_hit_c, ch_hit_c;

  assign id_at_c  = id_mem[idx_q[AW-1:0]];
  assign q_at_c   = q_mem[idx_q[AW-1:0]];
  assign ch_at_c  = ch_mem[idx_q[CAW-1:0]];
  assign rd_hit_c = {1'b0, rd_idx} < cnt_q;
  assign ch_hit_c = {1'b0, ch_rd_idx} < ch_cnt_q;

  // State register
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; clear forces IDLE from anywhere
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (wr_valid) state_d = SRCH;
      SRCH:   if (idx_q == cnt_q || id_at_c == rec_id_q) state_d = WRITE;
      WRITE:  state_d = (rec_cl_q == '0) ? QSCAN : CHSRCH;
      CHSRCH: if (idx_q == ch_cnt_q || ch_at_c == rec_cl_q) state_d = QSCAN;
      QSCAN:  if (idx_q == cnt_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // Datapath and output next values
  always_comb begin
    acc_c       = 1'b0;
    idx_d       = idx_q;
    hit_d       = hit_q;
    cnt_d       = cnt_q;
    ch_cnt_d    = ch_cnt_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    max_q_d     = max_q_q;
    max_q_id_d  = max_q_id_q;
    max_q_idx_d = max_q_idx_q;
    done_d      = 1'b0;
    ovf_d       = 1'b0;
    ch_ovf_d    = 1'b0;
    tbl_we_c    = 1'b0;
    tbl_wa_c    = idx_q[AW-1:0];
    ch_we_c     = 1'b0;
    ch_wa_c     = idx_q[CAW-1:0];
    unique case (state_q)
      IDLE: begin
        if (wr_valid) begin
          acc_c = 1'b1;
          idx_d = '0;
          hit_d = 1'b0;
        end
      end
      SRCH: begin
        if (idx_q == cnt_q)          hit_d = 1'b0;
        else if (id_at_c == rec_id_q) hit_d = 1'b1;
        else                          idx_d = idx_q + CW'(1);
      end
      WRITE: begin
        // idx_q holds the hit index on a hit and equals cnt_q on a miss
        if (hit_q) begin
          tbl_we_c = 1'b1;
        end else if (cnt_q < DEPTH_C) begin
          tbl_we_c = 1'b1;
          cnt_d    = cnt_q + CW'(1);
        end else begin
          ovf_d = 1'b1;
        end
        idx_d      = '0;
        best_d     = '0;
        best_idx_d = '0;
      end
      CHSRCH: begin
        if (idx_q == ch_cnt_q) begin
          if (ch_cnt_q < CH_DEPTH_C) begin
            ch_we_c  = 1'b1;
            ch_cnt_d = ch_cnt_q + CW'(1);
          end else begin
            ch_ovf_d = 1'b1;
          end
          idx_d = '0;
        end else if (ch_at_c == rec_cl_q) begin
          idx_d = '0;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      QSCAN: begin
        if (idx_q == cnt_q) begin
          max_q_d     = best_q;
          max_q_idx_d = best_idx_q;
          max_q_id_d  = (cnt_q == '0) ? '0 : id_mem[best_idx_q[AW-1:0]];
          done_d      = 1'b1;
        end else begin
          if (q_at_c > best_q) begin
            best_d     = q_at_c;
            best_idx_d = idx_q[IDX_W-1:0];
          end
          idx_d = idx_q + CW'(1);
        end
      end
      default: ;
    endcase
    if (clear) begin
      acc_c       = 1'b0;
      tbl_we_c    = 1'b0;
      ch_we_c     = 1'b0;
      cnt_d       = '0;
      ch_cnt_d    = '0;
      max_q_d     = '0;
      max_q_id_d  = '0;
      max_q_idx_d = '0;
      done_d      = 1'b0;
      ovf_d       = 1'b0;
      ch_ovf_d    = 1'b0;
    end
  end

  // Datapath, storage and read-port registers
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      idx_q <= '0; hit_q <= 1'b0; cnt_q <= '0; ch_cnt_q <= '0;
      best_q <= '0; best_idx_q <= '0;
      max_q_q <= '0; max_q_id_q <= '0; max_q_idx_q <= '0;
      done_q <= 1'b0; ovf_q <= 1'b0; ch_ovf_q <= 1'b0;
      rec_id_q <= '0; rec_cl_q <= '0; rec_en_q <= '0; rec_hp_q <= '0; rec_qv_q <= '0;
      id_mem <= '0; cl_mem <= '0; en_mem <= '0; hp_mem <= '0; q_mem <= '0; ch_mem <= '0;
      rd_id_q <= '0; rd_cl_q <= '0; rd_en_q <= '0; rd_hp_q <= '0; rd_qv_q <= '0;
      rd_hit_q <= 1'b0; ch_rd_q <= '0;
    end else begin
      idx_q <= idx_d; hit_q <= hit_d; cnt_q <= cnt_d; ch_cnt_q <= ch_cnt_d;
      best_q <= best_d; best_idx_q <= best_idx_d;
      max_q_q <= max_q_d; max_q_id_q <= max_q_id_d; max_q_idx_q <= max_q_idx_d;
      done_q <= done_d; ovf_q <= ovf_d; ch_ovf_q <= ch_ovf_d;
      if (acc_c) begin
        rec_id_q <= wr_id; rec_cl_q <= wr_cluster; rec_en_q <= wr_energy;
        rec_hp_q <= wr_hops; rec_qv_q <= wr_q;
      end
      if (tbl_we_c) begin
        id_mem[tbl_wa_c] <= rec_id_q; cl_mem[tbl_wa_c] <= rec_cl_q;
        en_mem[tbl_wa_c] <= rec_en_q; hp_mem[tbl_wa_c] <= rec_hp_q;
        q_mem[tbl_wa_c]  <= rec_qv_q;
      end
      if (ch_we_c) ch_mem[ch_wa_c] <= rec_cl_q;
      rd_hit_q <= rd_hit_c;
      rd_id_q  <= rd_hit_c ? id_mem[rd_idx[AW-1:0]] : '0;
      rd_cl_q  <= rd_hit_c ? cl_mem[rd_idx[AW-1:0]] : '0;
      rd_en_q  <= rd_hit_c ? en_mem[rd_idx[AW-1:0]] : '0;
      rd_hp_q  <= rd_hit_c ? hp_mem[rd_idx[AW-1:0]] : '0;
      rd_qv_q  <= rd_hit_c ? q_mem[rd_idx[AW-1:0]]  : '0;
      ch_rd_q  <= ch_hit_c ? ch_mem[ch_rd_idx[CAW-1:0]] : '0;
    end
  end

  assign wr_ready       = (state_q == IDLE);
  assign rd_id          = rd_id_q;
  assign rd_cluster     = rd_cl_q;
  assign rd_energy      = rd_en_q;
  assign rd_hops        = rd_hp_q;
  assign rd_q           = rd_qv_q;
  assign rd_hit         = rd_hit_q;
  assign ch_rd_id       = ch_rd_q;
  assign neighbor_count = cnt_q;
  assign ch_count       = ch_cnt_q;
  assign max_q          = max_q_q;
  assign max_q_id       = max_q_id_q;
  assign max_q_idx      = max_q_idx_q;
  assign done           = done_q;
  assign overflow       = ovf_q;
  assign ch_overflow    = ch_ovf_q;

endmodule

// File: tb/tb_neighbor_table_pq.sv
// Scoreboard bench for neighbor_table_pq: a behavioural table model predicts
// counts, max-Q, pulses and latency for each record and checks them at done.
module tb_neighbor_table_pq;
  localparam int unsigned W  = 16;
  localparam int unsigned D  = 16;
  localparam int unsigned CD = 8;
  localparam int unsigned IW = 4;

  logic clock = 1'b0;
  logic nrst = 1'b0, clear = 1'b0, wr_valid = 1'b0;
  logic wr_ready;
  logic [W-1:0] wr_id = '0, wr_cluster = '0, wr_energy = '0, wr_hops = '0, wr_q = '0;
  logic [IW-1:0] rd_idx = '0, ch_rd_idx = '0;
  logic [W-1:0] rd_id, rd_cluster, rd_energy, rd_hops, rd_q, ch_rd_id;
  logic rd_hit, done, overflow, ch_overflow;
  logic [IW:0] neighbor_count, ch_count;
  logic [W-1:0] max_q, max_q_id;
  logic [IW-1:0] max_q_idx;

  neighbor_table_pq #(.WORD_WIDTH(W), .DEPTH(D), .CH_DEPTH(CD), .IDX_W(IW)) dut (
    .clock(clock), .nrst(nrst), .clear(clear), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_id(wr_id), .wr_cluster(wr_cluster), .wr_energy(wr_energy), .wr_hops(wr_hops),
    .wr_q(wr_q), .rd_idx(rd_idx), .rd_id(rd_id), .rd_cluster(rd_cluster),
    .rd_energy(rd_energy), .rd_hops(rd_hops), .rd_q(rd_q), .rd_hit(rd_hit),
    .ch_rd_idx(ch_rd_idx), .ch_rd_id(ch_rd_id), .neighbor_count(neighbor_count),
    .ch_count(ch_count), .max_q(max_q), .max_q_id(max_q_id), .max_q_idx(max_q_idx),
    .done(done), .overflow(overflow), .ch_overflow(ch_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int lat; int n; int chn; int mq; int mqid; int mqidx; int ovf; int chovf;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int m_id[D], m_cl[D], m_q[D], m_ch[CD];
  int m_n = 0, m_chn = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    m_chn = 0;
    sb.delete();
  endtask

  // Apply one record to the model and push the expected outcome
  task automatic model_push(input int id, input int cl, input int q);
    exp_t e;
    int k, j, bq, bi;
    e.ovf = 0;
    e.chovf = 0;
    k = m_n;
    for (int i = m_n - 1; i >= 0; i--) if (m_id[i] == id) k = i;
    if (k < m_n) begin
      m_cl[k] = cl; m_q[k] = q;
    end else if (m_n < D) begin
      m_id[m_n] = id; m_cl[m_n] = cl; m_q[m_n] = q; m_n++;
    end else begin
      e.ovf = 1;
    end
    e.lat = k + 2;
    if (cl != 0) begin
      j = m_chn;
      for (int i = m_chn - 1; i >= 0; i--) if (m_ch[i] == cl) j = i;
      if (j == m_chn) begin
        if (m_chn < CD) begin m_ch[m_chn] = cl; m_chn++; end
        else e.chovf = 1;
      end
      e.lat += j + 1;
    end
    e.lat += m_n + 1;
    bq = 0; bi = 0;
    for (int i = 0; i < m_n; i++) if (m_q[i] > bq) begin bq = m_q[i]; bi = i; end
    e.n = m_n; e.chn = m_chn; e.mq = bq; e.mqidx = bi;
    e.mqid = (m_n > 0) ? m_id[bi] : 0;
    sb.push_back(e);
  endtask

  task automatic drive(input int id, input int cl, input int q);
    @(negedge clock);
    wr_valid = 1'b1;
    wr_id = W'(id); wr_cluster = W'(cl); wr_q = W'(q);
    wr_energy = W'(id + 1); wr_hops = W'(id + 2);
    @(posedge clock);
    #1 wr_valid = 1'b0;
  endtask

  task automatic send(input int id, input int cl, input int q);
    exp_t e;
    int lat, ovf_c, chovf_c;
    bit seen;
    model_push(id, cl, q);
    drive(id, cl, q);
    lat = 0; ovf_c = 0; chovf_c = 0; seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clock);
      #1;
      lat++;
      if (overflow) ovf_c++;
      if (ch_overflow) chovf_c++;
      if (done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 1);
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("wr_ready_at_done", 32'(wr_ready), 1);
    chk("neighbor_count", 32'(neighbor_count), e.n);
    chk("ch_count", 32'(ch_count), e.chn);
    chk("max_q", 32'(max_q), e.mq);
    chk("max_q_id", 32'(max_q_id), e.mqid);
    chk("max_q_idx", 32'(max_q_idx), e.mqidx);
    chk("overflow_pulses", ovf_c, e.ovf);
    chk("ch_overflow_pulses", chovf_c, e.chovf);
  endtask

  task automatic rd_chk(input int idx);
    bit h;
    h = (idx < m_n);
    @(negedge clock);
    rd_idx = IW'(idx);
    @(posedge clock);
    #1;
    chk("rd_hit", 32'(rd_hit), 32'(h));
    chk("rd_id", 32'(rd_id), h ? m_id[idx] : 0);
    chk("rd_cluster", 32'(rd_cluster), h ? m_cl[idx] : 0);
    chk("rd_energy", 32'(rd_energy), h ? m_id[idx] + 1 : 0);
    chk("rd_hops", 32'(rd_hops), h ? m_id[idx] + 2 : 0);
    chk("rd_q", 32'(rd_q), h ? m_q[idx] : 0);
  endtask

  task automatic ch_chk(input int idx);
    @(negedge clock);
    ch_rd_idx = IW'(idx);
    @(posedge clock);
    #1 chk("ch_rd_id", 32'(ch_rd_id), (idx < m_chn) ? m_ch[idx] : 0);
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    model_reset();
    chk("clear_count", 32'(neighbor_count), 0);
    chk("clear_ch_count", 32'(ch_count), 0);
  endtask

  task automatic no_done(input string tag, input int cycles);
    int d;
    d = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clock);
      #1 if (done) d++;
    end
    chk(tag, d, 0);
  endtask

  initial begin
    #2;
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_count", 32'(neighbor_count), 0);
    chk("rst_max_q", 32'(max_q), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clock);
    nrst = 1'b1;
    rd_chk(0);

    // First record into an empty table
    send(5, 2, 100);
    rd_chk(0);
    ch_chk(0);

    // Update of an existing id
    do_clear();
    send(1, 0, 10);
    send(2, 0, 50);
    send(3, 0, 30);
    send(2, 0, 5);
    rd_chk(1);

    // Table full, then one more new id
    do_clear();
    for (int i = 0; i < D; i++) send(10 + i, 0, (i * 37) % 101);
    send(99, 0, 500);
    for (int i = 0; i < D; i++) rd_chk(i);

    // CH list fill and overflow, duplicate and absent clusters
    do_clear();
    for (int i = 1; i <= 9; i++) send(i, i, i * 3);
    send(20, 3, 1);
    send(21, 0, 2);
    ch_chk(2);
    ch_chk(7);

    // Tie on max Q keeps the lower index
    do_clear();
    send(7, 0, 40);
    send(8, 0, 40);

    // clear during SRCH abandons the record
    drive(9, 4, 90);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    model_reset();
    chk("clr_wr_ready", 32'(wr_ready), 1);
    chk("clr_count", 32'(neighbor_count), 0);
    chk("clr_max_q", 32'(max_q), 0);
    no_done("clr_no_done", 12);
    rd_chk(3);

    // Asynchronous reset during QSCAN
    send(1, 0, 10);
    send(2, 0, 20);
    send(3, 0, 30);
    drive(1, 0, 5);
    repeat (3) @(posedge clock);
    #2 nrst = 1'b0;
    #1;
    chk("arst_wr_ready", 32'(wr_ready), 1);
    chk("arst_count", 32'(neighbor_count), 0);
    chk("arst_max_q", 32'(max_q), 0);
    chk("arst_max_q_id", 32'(max_q_id), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_rd_hit", 32'(rd_hit), 0);
    @(negedge clock);
    nrst = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    chk("post_rst_wr_ready", 32'(wr_ready), 1);
    chk("post_rst_count", 32'(neighbor_count), 0);
    no_done("post_rst_no_done", 8);
    send(5, 2, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
